// File: rtl/ps2_emit.sv
// PS/2-style device-side transmitter: one byte in per valid/ready handshake, one 11-bit frame out on clk/dat.
// Latency: bit 0 appears the cycle after acceptance; done pulses 22*HALF+1 cycles after acceptance.
// Backpressure: ready is low from acceptance until GAP cycles after done; valid while not ready is dropped.
module ps2_emit #(
  parameter int unsigned HALF = 4,  // sysclk cycles per serial clock half-period, 2..255
  parameter int unsigned GAP  = 8   // idle cycles after the stop bit before the next accept, 0..255
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [7:0] word,
  input  logic       valid,
  input  logic       bad_parity,
  output logic       ready,
  output logic       clk,
  output logic       dat,
  output logic       done
);

  localparam logic [7:0] HALF_LAST = 8'(HALF - 1);
  localparam logic [7:0] GAP_LAST  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
  localparam logic [3:0] LAST_BIT  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  half_q, half_d;    // position inside the current half-period
  logic        low_q, low_d;      // 0: high half of the bit, 1: low half
  logic [3:0]  bit_q, bit_d;      // index of the bit currently on dat
  logic [7:0]  gap_q, gap_d;      // cycles spent in the post-frame gap
  logic [10:0] shift_q, shift_d;  // frame bits, bit 0 is the one on dat
  logic        clk_q, clk_d;
  logic        done_q, done_d;

  // Odd parity over the data byte, optionally inverted to inject an error.
  logic par;
  assign par = ~(^word) ^ bad_parity;

  // Outputs come straight from flops so the serial lines never glitch.
  assign ready = (state_q == S_IDLE);
  assign clk   = clk_q;
  assign dat   = shift_q[0];
  assign done  = done_q;

  // Next-state logic: bit timing, frame sequencing and gap counting.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    low_d   = low_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    clk_d   = clk_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_d   = 1'b1;
        shift_d = '1;
        if (valid) begin
          // Capture the whole frame now so later word changes cannot leak in.
          shift_d = {1'b1, par, word, 1'b0};
          state_d = S_SHIFT;
          half_d  = 8'd0;
          low_d   = 1'b0;
          bit_d   = 4'd0;
        end
      end

      S_SHIFT: begin
        if (half_q == HALF_LAST) begin
          half_d = 8'd0;
          if (!low_q) begin
            // Mid-bit: drop clk while dat stays put.
            low_d = 1'b1;
            clk_d = 1'b0;
          end else begin
            // End of bit: raise clk and move dat in the same cycle.
            low_d = 1'b0;
            clk_d = 1'b1;
            if (bit_q == LAST_BIT) begin
              shift_d = '1;
              done_d  = 1'b1;
              gap_d   = 8'd0;
              state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = {1'b1, shift_q[10:1]};
            end
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end

      S_GAP: begin
        clk_d = 1'b1;
        // The done cycle is the first gap cycle, so no extra idle cycle appears.
        if (gap_q == GAP_LAST) begin
          gap_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        clk_d   = 1'b1;
        shift_d = '1;
      end
    endcase
  end

  // State register with synchronous reset; reset mid-frame abandons the frame.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      half_q  <= 8'd0;
      low_q   <= 1'b0;
      bit_q   <= 4'd0;
      gap_q   <= 8'd0;
      shift_q <= '1;
      clk_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      low_q   <= low_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      clk_q   <= clk_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ps2_emit.sv
// Bench for ps2_emit: random and directed traffic against a timeline model and a falling-edge receiver.
// Latency: compares every cycle, outputs sampled on the falling sysclk edge.
// Backpressure: valid is driven freely, the model decides which requests are accepted.
module tb_ps2_emit;

  localparam int HALF  = 4;
  localparam int GAP   = 8;
  localparam int BITP  = 2 * HALF;
  localparam int FRAME = 22 * HALF;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       bad_parity = 1'b0;
  logic [7:0] word = 8'd0;
  logic       ready, clk, dat, done;

  always #5 sysclk = ~sysclk;

  ps2_emit #(.HALF(HALF), .GAP(GAP)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .word      (word),
    .valid     (valid),
    .bad_parity(bad_parity),
    .ready     (ready),
    .clk       (clk),
    .dat       (dat),
    .done      (done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model: acceptance cycle plus the frame bits in flight.
  bit          have = 0;
  int          t_acc = 0;
  logic [10:0] fb = '1;
  logic [10:0] exp_q[$];

  // Receiver and observation state.
  logic        prev_clk = 1'b1;
  logic [10:0] rx_sh = '1;
  int          rx_n = 0;
  int          last_rx_par = -1;
  int          done_cyc = -1;
  bit          acc_now = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] w, input logic bp);
    int   ones;
    logic p;
    ones = $countones(w);
    p = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    p = p ^ bp;
    return {1'b1, p, w, 1'b0};
  endfunction

  task automatic monitor();
    logic e_clk, e_dat, e_rdy, e_done;
    int   k;
    e_clk = 1'b1; e_dat = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
    if (have) begin
      k = cyc - t_acc;
      if (k >= 1 && k <= FRAME) begin
        e_rdy = 1'b0;
        e_clk = (((k - 1) % BITP) < HALF);
        e_dat = fb[(k - 1) / BITP];
      end else if (k == FRAME + 1) begin
        e_done = 1'b1;
        e_rdy  = (GAP == 0);
      end else if (k <= FRAME + GAP) begin
        e_rdy = 1'b0;
      end else begin
        have = 0;
      end
    end
    if (chk_en) begin
      check("clk", clk, e_clk);
      check("dat", dat, e_dat);
      check("ready", ready, e_rdy);
      check("done", done, e_done);
    end
    acc_now = valid && ready && rst_n;
    if (done) done_cyc = cyc;
    if (chk_en && prev_clk && !clk) begin
      rx_sh[rx_n] = dat;
      rx_n++;
      if (rx_n == 11) begin
        if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
        else begin
          check("rx_byte", rx_sh[8:1], exp_q[0][8:1]);
          check("rx_frame", rx_sh, exp_q[0]);
          void'(exp_q.pop_front());
        end
        last_rx_par = rx_sh[9];
        rx_n = 0;
      end
    end
    prev_clk = clk;
    if (e_rdy && valid && rst_n) begin
      have  = 1;
      t_acc = cyc;
      fb    = make_frame(word, bad_parity);
      exp_q.push_back(fb);
    end
    if (!rst_n) begin
      have = 0;
      rx_n = 0;
      exp_q.delete();
    end
  endtask

  task automatic step(input logic v, input logic [7:0] w, input logic bp, input logic rn);
    @(posedge sysclk);
    cyc++;
    #1;
    valid = v; word = w; bad_parity = bp; rst_n = rn;
    @(negedge sysclk);
    monitor();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom), 1'($urandom), 1'b1);
  endtask

  // Holds valid until the DUT is seen accepting; returns the acceptance cycle.
  task automatic send(input logic [7:0] w, input logic bp, output int t);
    int n;
    n = 0;
    t = -1;
    while (t < 0 && n < 400) begin
      step(1'b1, w, bp, 1'b1);
      if (acc_now) t = cyc;
      n++;
    end
    if (t < 0) check("accept_timeout", 0, 1);
  endtask

  initial begin
    int t, t1, t2;

    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk_en = 1;
    check("rst_ready", ready, 1);
    check("rst_clk", clk, 1);
    check("rst_dat", dat, 1);
    check("rst_done", done, 0);
    repeat (50) step(1'b0, 8'h00, 1'b0, 1'b1);

    send(8'hA5, 1'b0, t);
    idle(100);
    check("a5_done_lat", done_cyc - t, FRAME + 1);
    check("a5_parity", last_rx_par, 1);

    send(8'h00, 1'b0, t); idle(100);
    check("par_00", last_rx_par, 1);
    send(8'h01, 1'b0, t); idle(100);
    check("par_01", last_rx_par, 0);
    send(8'hFF, 1'b0, t); idle(100);
    check("par_ff", last_rx_par, 1);
    send(8'h01, 1'b1, t); idle(100);
    check("par_01_bad", last_rx_par, 1);

    send(8'h12, 1'b0, t1);
    send(8'h34, 1'b0, t2);
    check("b2b_spacing", t2 - t1, FRAME + 1 + GAP);
    idle(100);

    done_cyc = -1;
    send(8'h5A, 1'b0, t);
    idle(39);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("abort_lat", cyc - t, 41);
    check("abort_clk", clk, 1);
    check("abort_dat", dat, 1);
    check("abort_ready", ready, 1);
    idle(60);
    check("abort_no_done", done_cyc, -1);
    send(8'hC3, 1'b0, t);
    idle(100);
    check("after_abort_done", done_cyc - t, FRAME + 1);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0, ($urandom % 500) != 0);
    end
    idle(120);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
